data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the core's data-memory port. It services the core's data address, read/write strobes and write data, and returns read data in the same cycle, as the single-cycle core requires. Behind the port sit a word RAM and an MMIO window. The MMIO window holds a 64-bit cycle counter and a console byte FIFO that drains over a valid/ready TX interface. The block sits beside the core at top level, and the core's data-port outputs connect straight to its inputs.

Parameters:
RAM_WORDS, 1024, RAM depth in 32-bit words; power of two; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
FIFO_DEPTH, 8, console FIFO depth in bytes; power of two, between 2 and 16.
MMIO_BASE, 32'hFFFF_0000, byte base address of the 16-byte MMIO window.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
data_addr  in  32  byte address from core; bits [1:0] ignored (word accesses only).
should_read_mem  in  1  read strobe for the current cycle.
should_write_mem  in  1  write strobe; the write commits at the end of the cycle.
mem_write_data  in  32  store data.
mem_read_data  out  32  combinational read data.
tx_valid  out  1  console FIFO non-empty.
tx_data  out  8  FIFO head byte.
tx_ready  in  1  sink accepts tx_data at posedge when tx_valid=1.
access_fault  out  1  registered one-cycle pulse on an access to an unmapped address.

Behaviour:
- Address decode, on word address data_addr[31:2]:
  - RAM if data_addr < 4*RAM_WORDS.
  - MMIO if data_addr[31:4] == MMIO_BASE[31:4]; the offset is data_addr[3:2].
  - Otherwise unmapped.
- mem_read_data is combinational, with zero-cycle latency:
  - should_read_mem=0 -> 32'h0.
  - RAM -> current word.
  - Unmapped -> 32'h0.
- MMIO offset 0x0, CYCLE_LO (RO): live cycle[31:0]. A read at posedge latches cycle[63:32] into hi_shadow.
- MMIO offset 0x4, CYCLE_HI (RO): returns hi_shadow. A LO-then-HI read pair is therefore coherent across the 32-bit carry.
- MMIO offset 0x8, CONSOLE_DATA (WO): a write pushes mem_write_data[7:0]. A read returns 0.
- MMIO offset 0xC, CONSOLE_STATUS:
  - Read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count; all other bits 0.
  - Write with bit2=1 clears overflow; other bits are ignored.
- Cycle counter: 64-bit, reset 0, increments every posedge and wraps from 2^64-1 to 0. Writes to CYCLE_LO/CYCLE_HI are ignored; they are not faults.
- RAM write: at posedge when should_write_mem=1 and the address is in RAM. The full word is written. RAM contents are not reset.
- Read and write strobes asserted in the same cycle: the write commits, and mem_read_data shows the pre-write value.
- Console FIFO, circular buffer with rd/wr pointers and count:
  - push = write to CONSOLE_DATA.
  - pop = tx_valid & tx_ready.
  - Push while full with no pop: byte dropped, overflow set.
  - Push while full with simultaneous pop: push accepted, count unchanged.
  - Push and pop while non-empty: count unchanged, both pointers advance.
  - tx_valid = (count != 0); tx_data = buffer[rd_ptr]. Both are stable until popped.
  - Pointers wrap modulo FIFO_DEPTH.
- access_fault is set for exactly the cycle after a posedge where (should_read_mem | should_write_mem) hit an unmapped address. An unmapped write changes no state.
- Reset values: cycle=0, hi_shadow=0, FIFO pointers/count=0, overflow=0, access_fault=0, tx_valid=0. tx_data is don't-care while tx_valid=0. mem_read_data follows its inputs.
- Reset mid-operation: FIFO contents are discarded, and a pending store in the reset cycle does not commit to MMIO. RAM is unaffected except for a write completed at an earlier posedge.

Test Plan:
1. Write 0xDEADBEEF to addr 0x10, then read 0x10 with read strobe -> mem_read_data=0xDEADBEEF in the same cycle; read of 0x13 -> 0xDEADBEEF (low bits ignored).
2. After reset, hold 5 cycles, then read CYCLE_LO -> 5. Force cycle to 0x0000_0000_FFFF_FFFF, read LO, then read HI the next cycle -> LO=0xFFFFFFFF, HI=0 (shadow, not live 1).
3. tx_ready=0: push 9 bytes 0x41..0x49 with FIFO_DEPTH=8 -> status full=1, count=8, overflow=1, 0x49 dropped. Write 0x4 to STATUS -> overflow=0.
4. FIFO full, push 0x5A while tx_ready=1 -> 0x41 popped, count stays 8, 0x5A is the last byte drained; draining yields 0x42..0x48, 0x5A in order.
5. Read addr 0x8000_0000 -> mem_read_data=0 and access_fault=1 for one cycle. Write there -> access_fault=1, RAM unchanged.
6. Assert reset asynchronously mid-cycle with 3 bytes queued -> tx_valid=0 and count=0 immediately; cycle=0 and access_fault=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-cycle data-port responder with word RAM, 64-bit cycle
// counter and a console byte FIFO draining over valid/ready.
module data_mem_responder #(
   parameter int          RAM_WORDS  = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic        should_read_mem,
   input  logic        should_write_mem,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        access_fault
);
   localparam int          AW        = $clog2(RAM_WORDS);
   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

   logic [31:0]   r_ram [RAM_WORDS];
   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [63:0]   r_cycle;
   logic [31:0]   r_hi;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [PW:0]   r_count;
   logic          r_ovf;
   logic          r_fault;

   logic          w_ram;
   logic          w_mmio;
   logic [1:0]    w_off;
   logic [AW-1:0] w_word;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_accept;
   logic          w_ovf_clr;
   logic [31:0]   w_status;
   logic [31:0]   w_mmio_rd;

   // full-width compare keeps the byte-offset bits in the decode; RAM_BYTES is word aligned
   assign w_ram     = {1'b0, data_addr} < RAM_BYTES;
   assign w_mmio    = data_addr[31:4] == MMIO_BASE[31:4];
   assign w_off     = data_addr[3:2];
   assign w_word    = data_addr[AW+1:2];
   assign w_full    = r_count == (PW+1)'(FIFO_DEPTH);
   assign w_empty   = r_count == '0;
   assign w_pop     = ~w_empty & tx_ready;
   assign w_push    = should_write_mem & w_mmio & (w_off == 2'd2);
   assign w_accept  = w_push & (~w_full | w_pop);
   assign w_ovf_clr = should_write_mem & w_mmio & (w_off == 2'd3) & mem_write_data[2];
   assign w_status  = {23'd0, 5'(r_count), 1'b0, r_ovf, w_empty, w_full};

   assign w_mmio_rd = (w_off == 2'd0) ? r_cycle[31:0] :
                      (w_off == 2'd1) ? r_hi :
                      (w_off == 2'd2) ? 32'd0 : w_status;

   assign mem_read_data = !should_read_mem ? 32'd0 :
                          w_ram            ? r_ram[w_word] :
                          w_mmio           ? w_mmio_rd : 32'd0;

   assign tx_valid     = ~w_empty;
   assign tx_data      = r_fifo[r_rd_ptr];
   assign access_fault = r_fault;

   always_ff @(posedge clk) begin
      if (!reset && should_write_mem && w_ram) r_ram[w_word] <= mem_write_data;
      if (!reset && w_accept) r_fifo[r_wr_ptr] <= mem_write_data[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle  <= '0;
         r_hi     <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         // snapshot the upper half with the low read so a LO/HI pair is coherent
         if (should_read_mem && w_mmio && w_off == 2'd0) r_hi <= r_cycle[63:32];
         r_fault <= (should_read_mem | should_write_mem) & ~w_ram & ~w_mmio;
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (PW+1)'(w_accept) - (PW+1)'(w_pop);
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized bench with a queue/array reference model of the
// data-port responder, plus directed literal checks of the key scenarios.
module tb_data_mem_responder;
   localparam int          RW = 1024;
   localparam int          FD = 8;
   localparam logic [31:0] MB = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_addr = '0;
   logic        should_read_mem = 1'b0;
   logic        should_write_mem = 1'b0;
   logic [31:0] mem_write_data = '0;
   logic [31:0] mem_read_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        access_fault;

   always #5 clk = ~clk;

   data_mem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .MMIO_BASE(MB)) dut (
      .clk(clk), .reset(reset), .data_addr(data_addr),
      .should_read_mem(should_read_mem), .should_write_mem(should_write_mem),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .access_fault(access_fault)
   );

   int err = 0;
   int chk = 0;

   logic [31:0] m_ram [RW];
   bit          m_ok [RW];
   logic [63:0] m_cycle;
   logic [31:0] m_hi;
   logic [7:0]  q [$];
   bit          m_ovf;
   bit          m_fault;

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'(RW * 4);
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return a >= MB && a - MB < 32'd16;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a >> 2) % RW;
   endfunction

   function automatic logic [31:0] exp_rd();
      int n;
      n = q.size();
      if (!should_read_mem) return 32'd0;
      if (is_ram(data_addr)) return m_ram[widx(data_addr)];
      if (!is_mmio(data_addr)) return 32'd0;
      case (int'((data_addr - MB) / 4))
         0: return m_cycle[31:0];
         1: return m_hi;
         2: return 32'd0;
         default: return 32'(n * 16 + (m_ovf ? 4 : 0) + (n == 0 ? 2 : 0) + (n == FD ? 1 : 0));
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cycle = '0;
      m_hi = '0;
      q.delete();
      m_ovf = 0;
      m_fault = 0;
   endtask

   task automatic model_check();
      if (!(should_read_mem && is_ram(data_addr) && !m_ok[widx(data_addr)]))
         check("rdata", mem_read_data, exp_rd());
      check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
      check("fault", 32'(access_fault), 32'(m_fault));
   endtask

   task automatic model_update();
      bit pop, full, mm, push;
      logic [7:0] dummy;
      pop  = q.size() != 0 && tx_ready;
      full = q.size() == FD;
      mm   = is_mmio(data_addr);
      push = should_write_mem && mm && data_addr - MB >= 8 && data_addr - MB < 12;
      if (pop) dummy = q.pop_front();
      if (push) begin
         if (full && !pop) m_ovf = 1;
         else q.push_back(mem_write_data[7:0]);
      end
      if (should_write_mem && mm && data_addr - MB >= 12 && mem_write_data[2]) m_ovf = 0;
      if (should_read_mem && mm && data_addr - MB < 4) m_hi = m_cycle[63:32];
      m_cycle = m_cycle + 1;
      if (should_write_mem && is_ram(data_addr)) begin
         m_ram[widx(data_addr)] = mem_write_data;
         m_ok[widx(data_addr)] = 1;
      end
      m_fault = (should_read_mem || should_write_mem) && !is_ram(data_addr) && !mm;
   endtask

   task automatic set_in(input logic [31:0] a, input bit rd, input bit wr,
                         input logic [31:0] wd, input bit rdy);
      data_addr = a;
      should_read_mem = rd;
      should_write_mem = wr;
      mem_write_data = wd;
      tx_ready = rdy;
   endtask

   task automatic mid();
      @(negedge clk);
      model_check();
   endtask

   task automatic fin();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc(input logic [31:0] a, input bit rd, input bit wr,
                      input logic [31:0] wd, input bit rdy);
      set_in(a, rd, wr, wd, rdy);
      mid();
      fin();
   endtask

   // reset asserted between edges, held across one posedge, released just after it
   task automatic do_reset(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd);
      set_in(a, rd, wr, wd, 1'b0);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_fault", 32'(access_fault), 32'd0);
      set_in(MB + 12, 1'b1, wr, wd, 1'b0);
      #1;
      check("rst_status", mem_read_data, 32'h2);
      set_in(MB, 1'b1, wr, wd, 1'b0);
      #1;
      check("rst_cycle", mem_read_data, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int k, r;
      model_reset();
      set_in(MB, 1'b1, 1'b0, 32'd0, 1'b0);
      #1;
      check("init_cycle", mem_read_data, 32'd0);
      check("init_tx_valid", 32'(tx_valid), 32'd0);
      check("init_fault", 32'(access_fault), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      repeat (5) cyc(32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      set_in(MB, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("cycle5", mem_read_data, 32'd5); fin();

      set_in(32'd0, 1'b0, 1'b0, 32'd0, 1'b0); mid();
      force dut.r_cycle = 64'h0000_0000_FFFF_FFFE;
      #1;
      release dut.r_cycle;
      m_cycle = 64'h0000_0000_FFFF_FFFE;
      fin();
      set_in(MB, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("lo_carry", mem_read_data, 32'hFFFF_FFFF); fin();
      set_in(MB + 4, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("hi_shadow", mem_read_data, 32'd0); fin();
      set_in(MB, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("lo_next", mem_read_data, 32'd1); fin();
      set_in(MB + 4, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("hi_next", mem_read_data, 32'd1); fin();

      cyc(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      cyc(32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
      set_in(32'h10, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("ram_rd", mem_read_data, 32'hDEAD_BEEF); fin();
      set_in(32'h13, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("ram_rd_low", mem_read_data, 32'hDEAD_BEEF); fin();
      set_in(32'h10, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0); mid();
      check("ram_rw_old", mem_read_data, 32'hDEAD_BEEF); fin();
      set_in(32'h10, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("ram_rw_new", mem_read_data, 32'hCAFE_F00D); fin();

      for (int i = 0; i < 9; i++) cyc(MB + 8, 1'b0, 1'b1, 32'h41 + 32'(i), 1'b0);
      set_in(MB + 12, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("status_full", mem_read_data, 32'h85);
      check("head_41", 32'(tx_data), 32'h41); fin();
      cyc(MB + 12, 1'b0, 1'b1, 32'h4, 1'b0);
      set_in(MB + 12, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("ovf_clr", mem_read_data, 32'h81); fin();
      set_in(MB + 8, 1'b0, 1'b1, 32'h5A, 1'b1); mid();
      check("pushpop_head", 32'(tx_data), 32'h41); fin();
      set_in(MB + 12, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("pushpop_cnt", mem_read_data, 32'h81); fin();
      for (int i = 0; i < 8; i++) begin
         set_in(32'd0, 1'b0, 1'b0, 32'd0, 1'b1); mid();
         check("drain", 32'(tx_data), i < 7 ? 32'h42 + 32'(i) : 32'h5A); fin();
      end
      set_in(32'd0, 1'b0, 1'b0, 32'd0, 1'b0); mid();
      check("drained", 32'(tx_valid), 32'd0); fin();

      set_in(32'h8000_0000, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("unmap_rd", mem_read_data, 32'd0); fin();
      set_in(32'd0, 1'b0, 1'b0, 32'd0, 1'b0); mid();
      check("fault_on", 32'(access_fault), 32'd1); fin();
      set_in(32'd0, 1'b0, 1'b0, 32'd0, 1'b0); mid();
      check("fault_off", 32'(access_fault), 32'd0); fin();
      cyc(32'h8000_0000, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
      set_in(32'h0, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("fault_wr", 32'(access_fault), 32'd1);
      check("ram_kept", mem_read_data, 32'h1111_1111); fin();

      for (int i = 0; i < 3; i++) cyc(MB + 8, 1'b0, 1'b1, 32'h61 + 32'(i), 1'b0);
      cyc(32'h8000_0000, 1'b1, 1'b0, 32'd0, 1'b0);
      do_reset(MB + 8, 1'b0, 1'b1, 32'h77);
      set_in(MB, 1'b1, 1'b0, 32'd0, 1'b0); mid();
      check("post_rst_lo", mem_read_data, 32'd0);
      check("post_rst_tx", 32'(tx_valid), 32'd0); fin();

      for (int n = 0; n < 3000; n++) begin
         k = $urandom_range(0, 9);
         r = $urandom_range(0, 7);
         if (k <= 3) a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
         else if (k == 4) a = ($urandom_range(0, 1) ? 32'(RW * 4 - 4) : 32'(RW * 4)) + $urandom_range(0, 3);
         else if (k <= 7) a = MB + (r < 4 ? 32'd8 : 32'(r - 4) * 4) + $urandom_range(0, 3);
         else if (k == 8) a = $urandom;
         else a = $urandom_range(0, 1) ? MB + 16 : MB - 4;
         if (n == 1500) do_reset(a, 1'b0, 1'b1, $urandom);
         else cyc(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3) == 0);
      end

      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end
endmodule
